mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_req_slot.sv | 38 +++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// common -- shared types for the memory arbiter slice.
//   pptr_t       physical line address
//   cacheline_t  one cache line of data
//   arb_state_t  arbiter FSM state (IDLE / WAIT)
//   owner_t      which cache owns an outstanding read (also the rr pointer)
//   MEM_TIMEOUT  default number of WAIT cycles before a read is abandoned
// ---------------------------------------------------------------------------
package common;
   localparam int PADDR_W     = 32;
   localparam int LINE_W      = 128;
   localparam int MEM_TIMEOUT = 64;

   typedef logic [PADDR_W-1:0] pptr_t;
   typedef logic [LINE_W-1:0]  cacheline_t;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if -- bundles the i-cache, d-cache and memory buses.
//   slave  : arbiter view (cache requests and memory responses in,
//            cache fills, ready flags and memory requests out)
//   master : environment view (the opposite directions)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
   import common::*;

   logic       icache_req_ren;
   pptr_t      icache_req_raddr;
   logic       icache_req_ready;
   logic       icache_rec_en;
   pptr_t      icache_rec_addr;
   cacheline_t icache_rec_cacheline;

   logic       dcache_req_ren;
   pptr_t      dcache_req_raddr;
   logic       dcache_req_wen;
   pptr_t      dcache_req_waddr;
   cacheline_t dcache_req_wcacheline;
   logic       dcache_req_ready;
   logic       dcache_rec_en;
   pptr_t      dcache_rec_addr;
   cacheline_t dcache_rec_cacheline;

   logic       mem_req_ren;
   pptr_t      mem_req_raddr;
   logic       mem_req_wen;
   pptr_t      mem_req_waddr;
   cacheline_t mem_req_wcacheline;
   logic       mem_rec_en;
   pptr_t      mem_rec_addr;
   cacheline_t mem_rec_cacheline;

   modport slave (
      input  icache_req_ren, icache_req_raddr,
      output icache_req_ready, icache_rec_en, icache_rec_addr, icache_rec_cacheline,
      input  dcache_req_ren, dcache_req_raddr, dcache_req_wen, dcache_req_waddr,
             dcache_req_wcacheline,
      output dcache_req_ready, dcache_rec_en, dcache_rec_addr, dcache_rec_cacheline,
      output mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
      input  mem_rec_en, mem_rec_addr, mem_rec_cacheline
   );

   modport master (
      output icache_req_ren, icache_req_raddr,
      input  icache_req_ready, icache_rec_en, icache_rec_addr, icache_rec_cacheline,
      output dcache_req_ren, dcache_req_raddr, dcache_req_wen, dcache_req_waddr,
             dcache_req_wcacheline,
      input  dcache_req_ready, dcache_rec_en, dcache_rec_addr, dcache_rec_cacheline,
      input  mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
      output mem_rec_en, mem_rec_addr, mem_rec_cacheline
   );
endinterface

// File: rtl/mem_arbiter_req_slot.sv
// ---------------------------------------------------------------------------
// req_slot -- one pending-request register: a valid flag plus a payload.
//   clk, rst   clock, synchronous active-low reset
//   i_capture  load i_data and set valid
//   i_clear    drop the held request
//   i_data     payload to capture (address, or address and line)
//   o_valid    slot holds a request
//   o_data     held payload
// ---------------------------------------------------------------------------
module req_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_capture,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);
   logic         r_valid;
   logic [W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- shares one memory port between an i-cache and a d-cache.
//   clk, rst     clock, synchronous active-low reset
//   bus          mem_arbiter_if.slave: cache requests/fills, memory req/resp
//   err_timeout  one-cycle pulse when an outstanding read is abandoned
// Writebacks win outright; reads alternate between caches and hold the
// memory port until the matching response arrives or TIMEOUT expires.
// ---------------------------------------------------------------------------
module mem_arbiter
   import common::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         err_timeout
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   // slot wires
   logic  w_i_valid, w_dr_valid, w_dw_valid;
   logic  w_i_cap, w_dr_cap, w_dw_cap;
   logic  w_i_clr, w_dr_clr, w_dw_clr;
   pptr_t w_i_addr, w_dr_addr, w_dw_addr;
   cacheline_t w_dw_line;
   logic [PADDR_W+LINE_W-1:0] w_dw_data;

   // FSM and registered outputs
   arb_state_t r_state, w_state_next;
   owner_t     r_rr, w_rr_next, r_owner, w_owner_next;
   pptr_t      r_addr, w_addr_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic       r_mem_ren, w_mem_ren_next, r_mem_wen, w_mem_wen_next;
   pptr_t      r_mem_raddr, w_mem_raddr_next, r_mem_waddr, w_mem_waddr_next;
   cacheline_t r_mem_wline, w_mem_wline_next;
   logic       r_irec_en, w_irec_en_next, r_drec_en, w_drec_en_next;
   pptr_t      r_irec_addr, w_irec_addr_next, r_drec_addr, w_drec_addr_next;
   cacheline_t r_irec_line, w_irec_line_next, r_drec_line, w_drec_line_next;
   logic       r_err, w_err_next;
   logic       w_pick_i, w_match;

   // Ready is purely slot occupancy; the d-cache port has a single ready
   // so a read and a writeback can be offered together.
   assign bus.icache_req_ready = !w_i_valid;
   assign bus.dcache_req_ready = !w_dr_valid && !w_dw_valid;

   assign w_i_cap  = bus.icache_req_ren && !w_i_valid;
   assign w_dr_cap = bus.dcache_req_ren && bus.dcache_req_ready;
   assign w_dw_cap = bus.dcache_req_wen && bus.dcache_req_ready;

   req_slot #(.W(PADDR_W)) u_i_slot (
      .clk(clk), .rst(rst), .i_capture(w_i_cap), .i_clear(w_i_clr),
      .i_data(bus.icache_req_raddr), .o_valid(w_i_valid), .o_data(w_i_addr));

   req_slot #(.W(PADDR_W)) u_dr_slot (
      .clk(clk), .rst(rst), .i_capture(w_dr_cap), .i_clear(w_dr_clr),
      .i_data(bus.dcache_req_raddr), .o_valid(w_dr_valid), .o_data(w_dr_addr));

   req_slot #(.W(PADDR_W + LINE_W)) u_dw_slot (
      .clk(clk), .rst(rst), .i_capture(w_dw_cap), .i_clear(w_dw_clr),
      .i_data({bus.dcache_req_waddr, bus.dcache_req_wcacheline}),
      .o_valid(w_dw_valid), .o_data(w_dw_data));

   assign {w_dw_addr, w_dw_line} = w_dw_data;

   assign w_match = bus.mem_rec_en && (bus.mem_rec_addr == r_addr);

   always_comb begin
      w_state_next     = r_state;
      w_rr_next        = r_rr;
      w_owner_next     = r_owner;
      w_addr_next      = r_addr;
      w_cnt_next       = r_cnt;
      w_mem_ren_next   = 1'b0;
      w_mem_raddr_next = r_mem_raddr;
      w_mem_wen_next   = 1'b0;
      w_mem_waddr_next = r_mem_waddr;
      w_mem_wline_next = r_mem_wline;
      w_irec_en_next   = 1'b0;
      w_irec_addr_next = r_irec_addr;
      w_irec_line_next = r_irec_line;
      w_drec_en_next   = 1'b0;
      w_drec_addr_next = r_drec_addr;
      w_drec_line_next = r_drec_line;
      w_err_next       = 1'b0;
      w_i_clr          = 1'b0;
      w_dr_clr         = 1'b0;
      w_dw_clr         = 1'b0;
      w_pick_i         = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_dw_valid) begin
               // Writes need no response, so the FSM stays in IDLE.
               w_mem_wen_next   = 1'b1;
               w_mem_waddr_next = w_dw_addr;
               w_mem_wline_next = w_dw_line;
               w_dw_clr         = 1'b1;
            end else if (w_i_valid || w_dr_valid) begin
               w_pick_i         = w_i_valid && (!w_dr_valid || r_rr == OWN_I);
               w_owner_next     = w_pick_i ? OWN_I : OWN_D;
               w_addr_next      = w_pick_i ? w_i_addr : w_dr_addr;
               w_mem_ren_next   = 1'b1;
               w_mem_raddr_next = w_addr_next;
               w_rr_next        = (r_rr == OWN_I) ? OWN_D : OWN_I;
               w_cnt_next       = '0;
               w_state_next     = WAIT;
            end
         end
         WAIT: begin
            // A matching response beats the timeout in the same cycle.
            if (w_match) begin
               if (r_owner == OWN_I) begin
                  w_irec_en_next   = 1'b1;
                  w_irec_addr_next = r_addr;
                  w_irec_line_next = bus.mem_rec_cacheline;
                  w_i_clr          = 1'b1;
               end else begin
                  w_drec_en_next   = 1'b1;
                  w_drec_addr_next = r_addr;
                  w_drec_line_next = bus.mem_rec_cacheline;
                  w_dr_clr         = 1'b1;
               end
               w_state_next = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_err_next   = 1'b1;
               w_i_clr      = (r_owner == OWN_I);
               w_dr_clr     = (r_owner == OWN_D);
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rr        <= OWN_I;
         r_owner     <= OWN_I;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_mem_ren   <= 1'b0;
         r_mem_raddr <= '0;
         r_mem_wen   <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wline <= '0;
         r_irec_en   <= 1'b0;
         r_irec_addr <= '0;
         r_irec_line <= '0;
         r_drec_en   <= 1'b0;
         r_drec_addr <= '0;
         r_drec_line <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_rr        <= w_rr_next;
         r_owner     <= w_owner_next;
         r_addr      <= w_addr_next;
         r_cnt       <= w_cnt_next;
         r_mem_ren   <= w_mem_ren_next;
         r_mem_raddr <= w_mem_raddr_next;
         r_mem_wen   <= w_mem_wen_next;
         r_mem_waddr <= w_mem_waddr_next;
         r_mem_wline <= w_mem_wline_next;
         r_irec_en   <= w_irec_en_next;
         r_irec_addr <= w_irec_addr_next;
         r_irec_line <= w_irec_line_next;
         r_drec_en   <= w_drec_en_next;
         r_drec_addr <= w_drec_addr_next;
         r_drec_line <= w_drec_line_next;
         r_err       <= w_err_next;
      end
   end

   assign bus.mem_req_ren          = r_mem_ren;
   assign bus.mem_req_raddr        = r_mem_raddr;
   assign bus.mem_req_wen          = r_mem_wen;
   assign bus.mem_req_waddr        = r_mem_waddr;
   assign bus.mem_req_wcacheline   = r_mem_wline;
   assign bus.icache_rec_en        = r_irec_en;
   assign bus.icache_rec_addr      = r_irec_addr;
   assign bus.icache_rec_cacheline = r_irec_line;
   assign bus.dcache_rec_en        = r_drec_en;
   assign bus.dcache_rec_addr      = r_drec_addr;
   assign bus.dcache_rec_cacheline = r_drec_line;
   assign err_timeout              = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- directed bench for mem_arbiter (TIMEOUT = 8).
// Inputs change and outputs are sampled on the falling edge; "cycle n"
// is the clock period in which a value is visible at that falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
   import common::*;

   logic clk;
   logic rst;
   logic err_timeout;
   int   total = 0;
   int   bad   = 0;

   localparam cacheline_t LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam cacheline_t LINE_B = 128'hA5A5_0000_FFFF_1111_2222_3333_4444_5A5A;
   localparam cacheline_t LINE_C = 128'hCAFE_F00D_DEAD_BEEF_1357_9BDF_2468_ACE0;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .err_timeout(err_timeout));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.icache_req_ren = 1'b0;  bus.icache_req_raddr = '0;
      bus.dcache_req_ren = 1'b0;  bus.dcache_req_raddr = '0;
      bus.dcache_req_wen = 1'b0;  bus.dcache_req_waddr = '0;
      bus.dcache_req_wcacheline = '0;
      bus.mem_rec_en = 1'b0;      bus.mem_rec_addr = '0;
      bus.mem_rec_cacheline = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b11) begin
         bad++; $display("FAIL reset_ready: got %b want 11", {bus.icache_req_ready, bus.dcache_req_ready});
      end
      total++;
      if ({bus.mem_req_ren, bus.mem_req_wen, bus.icache_rec_en, bus.dcache_rec_en, err_timeout} !== 5'b0) begin
         bad++; $display("FAIL reset_pulses: got %b want 00000",
            {bus.mem_req_ren, bus.mem_req_wen, bus.icache_rec_en, bus.dcache_rec_en, err_timeout});
      end
      total++;
      if (bus.mem_req_raddr !== '0 || bus.icache_rec_addr !== '0) begin
         bad++; $display("FAIL reset_addr: raddr %h rec_addr %h want 0", bus.mem_req_raddr, bus.icache_rec_addr);
      end
      $display("reset checked");
   endtask

   task automatic test_single_read();
      do_reset();
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h100;        // cycle 0
      step(); bus.icache_req_ren = 1'b0;                                 // cycle 1
      total++;
      if (bus.icache_req_ready !== 1'b0 || bus.mem_req_ren !== 1'b0) begin
         bad++; $display("FAIL read_c1: ready %b ren %b want 0 0", bus.icache_req_ready, bus.mem_req_ren);
      end
      step();                                                            // cycle 2
      total++;
      if (bus.mem_req_ren !== 1'b1 || bus.mem_req_raddr !== 32'h100 || bus.mem_req_wen !== 1'b0) begin
         bad++; $display("FAIL read_grant: ren %b raddr %h wen %b want 1 100 0",
            bus.mem_req_ren, bus.mem_req_raddr, bus.mem_req_wen);
      end
      step();                                                            // cycle 3
      total++;
      if (bus.mem_req_ren !== 1'b0) begin
         bad++; $display("FAIL read_pulse: ren %b want 0", bus.mem_req_ren);
      end
      step();                                                            // cycle 4
      step();                                                            // cycle 5
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h100; bus.mem_rec_cacheline = LINE_A;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 6
      total++;
      if (bus.icache_rec_en !== 1'b1 || bus.dcache_rec_en !== 1'b0 || bus.icache_rec_addr !== 32'h100
          || bus.icache_rec_cacheline !== LINE_A) begin
         bad++; $display("FAIL read_fill: ien %b den %b addr %h line %h want 1 0 100 %h",
            bus.icache_rec_en, bus.dcache_rec_en, bus.icache_rec_addr, bus.icache_rec_cacheline, LINE_A);
      end
      step();                                                            // cycle 7
      total++;
      if (bus.icache_rec_en !== 1'b0 || bus.icache_req_ready !== 1'b1) begin
         bad++; $display("FAIL read_done: ien %b ready %b want 0 1", bus.icache_rec_en, bus.icache_req_ready);
      end
      $display("single read 0x100 done");
   endtask

   task automatic test_write_then_read();
      do_reset();
      bus.dcache_req_wen = 1'b1; bus.dcache_req_waddr = 32'h200; bus.dcache_req_wcacheline = LINE_B;
      bus.dcache_req_ren = 1'b1; bus.dcache_req_raddr = 32'h300;         // cycle 0
      step(); bus.dcache_req_wen = 1'b0; bus.dcache_req_ren = 1'b0;      // cycle 1
      total++;
      if (bus.dcache_req_ready !== 1'b0) begin
         bad++; $display("FAIL wr_ready: got %b want 0", bus.dcache_req_ready);
      end
      step();                                                            // cycle 2
      total++;
      if (bus.mem_req_wen !== 1'b1 || bus.mem_req_ren !== 1'b0 || bus.mem_req_waddr !== 32'h200
          || bus.mem_req_wcacheline !== LINE_B) begin
         bad++; $display("FAIL wr_first: wen %b ren %b waddr %h want 1 0 200",
            bus.mem_req_wen, bus.mem_req_ren, bus.mem_req_waddr);
      end
      step();                                                            // cycle 3
      total++;
      if (bus.mem_req_ren !== 1'b1 || bus.mem_req_wen !== 1'b0 || bus.mem_req_raddr !== 32'h300) begin
         bad++; $display("FAIL rd_second: ren %b wen %b raddr %h want 1 0 300",
            bus.mem_req_ren, bus.mem_req_wen, bus.mem_req_raddr);
      end
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h300; bus.mem_rec_cacheline = LINE_C;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 4
      total++;
      if ({bus.icache_rec_en, bus.dcache_rec_en} !== 2'b01 || bus.dcache_rec_addr !== 32'h300
          || bus.dcache_rec_cacheline !== LINE_C) begin
         bad++; $display("FAIL d_fill: en %b addr %h want 01 300",
            {bus.icache_rec_en, bus.dcache_rec_en}, bus.dcache_rec_addr);
      end
      step();                                                            // cycle 5
      total++;
      if (bus.dcache_req_ready !== 1'b1) begin
         bad++; $display("FAIL d_ready_after: got %b want 1", bus.dcache_req_ready);
      end
      $display("write 0x200 then read 0x300 done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.dcache_req_wen = 1'b1; bus.dcache_req_wcacheline = LINE_A;
      bus.dcache_req_waddr = 32'hA00;                                    // cycle 0: accepted
      step(); bus.dcache_req_waddr = 32'hB00;                            // cycle 1: ready=0, dropped
      step(); bus.dcache_req_waddr = 32'hC00;                            // cycle 2: accepted
      total++;
      if (bus.mem_req_wen !== 1'b1 || bus.mem_req_waddr !== 32'hA00) begin
         bad++; $display("FAIL b2b_first: wen %b waddr %h want 1 a00", bus.mem_req_wen, bus.mem_req_waddr);
      end
      step(); bus.dcache_req_wen = 1'b0;                                 // cycle 3
      total++;
      if (bus.mem_req_wen !== 1'b0) begin
         bad++; $display("FAIL b2b_gap: wen %b waddr %h want 0", bus.mem_req_wen, bus.mem_req_waddr);
      end
      step();                                                            // cycle 4
      total++;
      if (bus.mem_req_wen !== 1'b1 || bus.mem_req_waddr !== 32'hC00) begin
         bad++; $display("FAIL b2b_second: wen %b waddr %h want 1 c00", bus.mem_req_wen, bus.mem_req_waddr);
      end
      step();                                                            // cycle 5
      total++;
      if (bus.mem_req_wen !== 1'b0 || bus.mem_req_ren !== 1'b0) begin
         bad++; $display("FAIL b2b_end: wen %b ren %b want 0 0", bus.mem_req_wen, bus.mem_req_ren);
      end
      $display("back-to-back writes a00, c00 done");
   endtask

   task automatic test_round_robin();
      pptr_t exp_addr;
      int    n;
      do_reset();
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h10;
      bus.dcache_req_ren = 1'b1; bus.dcache_req_raddr = 32'h20;
      step(); bus.icache_req_ren = 1'b0; bus.dcache_req_ren = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 0) ? 32'h10 : 32'h20;
         n = 0;
         while (bus.mem_req_ren !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         total++;
         if (n == 10) begin
            bad++; $display("FAIL rr_wait: no grant in 10 cycles for grant %0d, want raddr %h", k, exp_addr);
         end
         total++;
         if (bus.mem_req_raddr !== exp_addr) begin
            bad++; $display("FAIL rr_order: grant %0d raddr %h want %h", k, bus.mem_req_raddr, exp_addr);
         end
         $display("rr grant %0d raddr %h", k, bus.mem_req_raddr);
         bus.mem_rec_en = 1'b1; bus.mem_rec_addr = exp_addr; bus.mem_rec_cacheline = LINE_B;
         step(); bus.mem_rec_en = 1'b0;
         total++;
         if ({bus.icache_rec_en, bus.dcache_rec_en} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_fill: grant %0d rec_en %b want %b", k,
               {bus.icache_rec_en, bus.dcache_rec_en}, (k % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (k == 0) bus.icache_req_ren = 1'b1;
         if (k == 1) bus.dcache_req_ren = 1'b1;
         step(); bus.icache_req_ren = 1'b0; bus.dcache_req_ren = 1'b0;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h50;
      bus.dcache_req_ren = 1'b1; bus.dcache_req_raddr = 32'h60;          // cycle 0
      step(); bus.icache_req_ren = 1'b0; bus.dcache_req_ren = 1'b0;      // cycle 1
      step();                                                            // cycle 2: WAIT entry
      total++;
      if (bus.mem_req_ren !== 1'b1 || bus.mem_req_raddr !== 32'h50) begin
         bad++; $display("FAIL to_grant: ren %b raddr %h want 1 50", bus.mem_req_ren, bus.mem_req_raddr);
      end
      for (int k = 0; k < 8; k++) begin                                  // cycles 2..9
         total++;
         if (err_timeout !== 1'b0 || bus.icache_rec_en !== 1'b0) begin
            bad++; $display("FAIL to_early: cycle %0d err %b ien %b want 0 0", k + 2, err_timeout, bus.icache_rec_en);
         end
         step();
      end
      total++;                                                           // cycle 10
      if (err_timeout !== 1'b1 || bus.icache_rec_en !== 1'b0 || bus.icache_req_ready !== 1'b1) begin
         bad++; $display("FAIL to_pulse: err %b ien %b ready %b want 1 0 1",
            err_timeout, bus.icache_rec_en, bus.icache_req_ready);
      end
      step();                                                            // cycle 11
      total++;
      if (err_timeout !== 1'b0 || bus.mem_req_ren !== 1'b1 || bus.mem_req_raddr !== 32'h60) begin
         bad++; $display("FAIL to_next: err %b ren %b raddr %h want 0 1 60",
            err_timeout, bus.mem_req_ren, bus.mem_req_raddr);
      end
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h60; bus.mem_rec_cacheline = LINE_A;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 12
      total++;
      if ({bus.icache_rec_en, bus.dcache_rec_en} !== 2'b01) begin
         bad++; $display("FAIL to_next_fill: rec_en %b want 01", {bus.icache_rec_en, bus.dcache_rec_en});
      end
      $display("timeout on 0x50, then 0x60 served");
   endtask

   task automatic test_match_at_timeout();
      do_reset();
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h58;          // cycle 0
      step(); bus.icache_req_ren = 1'b0;                                 // cycle 1
      for (int k = 0; k < 8; k++) step();                                // cycle 9: last WAIT cycle
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h58; bus.mem_rec_cacheline = LINE_C;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 10
      total++;
      if (bus.icache_rec_en !== 1'b1 || err_timeout !== 1'b0 || bus.icache_rec_cacheline !== LINE_C) begin
         bad++; $display("FAIL match_vs_timeout: ien %b err %b want 1 0", bus.icache_rec_en, err_timeout);
      end
      step();                                                            // cycle 11
      total++;
      if (err_timeout !== 1'b0) begin
         bad++; $display("FAIL match_vs_timeout_after: err %b want 0", err_timeout);
      end
      $display("match on last WAIT cycle of 0x58 done");
   endtask

   task automatic test_mismatch();
      do_reset();
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h40; bus.mem_rec_cacheline = LINE_A;
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h40;         // cycle 0: rec in IDLE
      step(); bus.mem_rec_en = 1'b0; bus.icache_req_ren = 1'b0;         // cycle 1
      total++;
      if ({bus.icache_rec_en, bus.dcache_rec_en} !== 2'b00) begin
         bad++; $display("FAIL idle_rec: rec_en %b want 00", {bus.icache_rec_en, bus.dcache_rec_en});
      end
      step();                                                            // cycle 2
      step();                                                            // cycle 3
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h80; bus.mem_rec_cacheline = LINE_B;
      step();                                                            // cycle 4
      total++;
      if ({bus.icache_rec_en, bus.dcache_rec_en} !== 2'b00) begin
         bad++; $display("FAIL wrong_addr: rec_en %b want 00", {bus.icache_rec_en, bus.dcache_rec_en});
      end
      bus.mem_rec_addr = 32'h40; bus.mem_rec_cacheline = LINE_C;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 5
      total++;
      if (bus.icache_rec_en !== 1'b1 || bus.icache_rec_addr !== 32'h40 || bus.icache_rec_cacheline !== LINE_C) begin
         bad++; $display("FAIL right_addr: ien %b addr %h want 1 40", bus.icache_rec_en, bus.icache_rec_addr);
      end
      $display("mismatch 0x80 ignored, 0x40 filled");
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      bus.icache_req_ren = 1'b1; bus.icache_req_raddr = 32'h70;          // cycle 0
      step(); bus.icache_req_ren = 1'b0;                                 // cycle 1
      step();                                                            // cycle 2: granted
      step(); rst = 1'b0;                                                // cycle 3
      step(); rst = 1'b1;                                                // cycle 4
      total++;
      if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b11 || bus.mem_req_ren !== 1'b0) begin
         bad++; $display("FAIL rst_wait_ready: ready %b ren %b want 11 0",
            {bus.icache_req_ready, bus.dcache_req_ready}, bus.mem_req_ren);
      end
      bus.mem_rec_en = 1'b1; bus.mem_rec_addr = 32'h70; bus.mem_rec_cacheline = LINE_A;
      step(); bus.mem_rec_en = 1'b0;                                     // cycle 5
      total++;
      if ({bus.icache_rec_en, bus.dcache_rec_en} !== 2'b00 || bus.mem_req_ren !== 1'b0) begin
         bad++; $display("FAIL rst_wait_fill: rec_en %b ren %b want 00 0",
            {bus.icache_rec_en, bus.dcache_rec_en}, bus.mem_req_ren);
      end
      $display("reset during WAIT on 0x70 done");
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_write_then_read();
      test_back_to_back();
      test_round_robin();
      test_timeout();
      test_match_at_timeout();
      test_mismatch();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, want finished");
      $fatal(1, "watchdog expired");
   end
endmodule
